// File: rtl/riscv_prefetch_buffer_ot_if.sv
// Fetch-side and instruction-bus signals of the prefetch buffer.
// master: the prefetch buffer itself; slave: the IF stage and instruction memory around it.
interface riscv_prefetch_buffer_ot_if;
    logic        req_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        fetch_ready_i;
    logic        fetch_valid_o;
    logic [31:0] fetch_rdata_o;
    logic [31:0] fetch_addr_o;
    logic        fetch_err_o;
    logic        instr_req_o;
    logic        instr_gnt_i;
    logic [31:0] instr_addr_o;
    logic [31:0] instr_rdata_i;
    logic        instr_rvalid_i;
    logic        instr_err_i;
    logic        busy_o;

    modport master (
        input  req_i, branch_i, branch_addr_i, fetch_ready_i,
        input  instr_gnt_i, instr_rdata_i, instr_rvalid_i, instr_err_i,
        output fetch_valid_o, fetch_rdata_o, fetch_addr_o, fetch_err_o,
        output instr_req_o, instr_addr_o, busy_o
    );

    modport slave (
        output req_i, branch_i, branch_addr_i, fetch_ready_i,
        output instr_gnt_i, instr_rdata_i, instr_rvalid_i, instr_err_i,
        input  fetch_valid_o, fetch_rdata_o, fetch_addr_o, fetch_err_o,
        input  instr_req_o, instr_addr_o, busy_o
    );
endinterface

// File: rtl/riscv_prefetch_buffer_ot.sv
// Instruction prefetch buffer: sequential word fetches with up to MAX_OT outstanding
// bus requests, a DEPTH-entry response FIFO, stream squash on branch and halt on bus error.
// Optional feature: define RISCV_PREFETCH_BYPASS_EN to forward a response straight to the
// fetch port when the FIFO is empty (otherwise every response is registered first).
module riscv_prefetch_buffer_ot #(
    parameter int DEPTH  = 4,
    parameter int MAX_OT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    riscv_prefetch_buffer_ot_if.master bus
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int OTW = $clog2(MAX_OT + 1);
    localparam int AQW = (MAX_OT > 1) ? $clog2(MAX_OT) : 1;
    localparam int SW  = $clog2(DEPTH + MAX_OT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_GNT, ERR_HALT} state_e;

    state_e         state_q;
    logic           boot_q;
    logic [31:0]    addr_q;
    logic [OTW-1:0] ot_q;
    logic [OTW-1:0] ot_nxt;
    logic [OTW-1:0] discard_q;
    logic [CW-1:0]  fifo_cnt_q;
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [AQW-1:0] aq_wr_q;
    logic [AQW-1:0] aq_rd_q;
    logic [31:0]    rdata_mem [DEPTH];
    logic [31:0]    addr_mem  [DEPTH];
    logic           err_mem   [DEPTH];
    logic [31:0]    aq_mem    [MAX_OT];

    logic        ot_room, can_issue, req, gnt, rvalid, drop, rsp_acc, rsp_err;
    logic        head_vld, byp, fetch_vld, fetch_pop, fifo_push, fifo_pop;
    logic [31:0] req_addr, rsp_addr;
    logic [31:0] out_rdata, out_addr;
    logic        out_err;
    logic        unused_addr_lsb;

    // Wrap-around increment for the outstanding-address queue (depth need not be a power of two)
    function automatic logic [AQW-1:0] aq_inc(input logic [AQW-1:0] p);
        return (p == AQW'(MAX_OT - 1)) ? '0 : p + AQW'(1);
    endfunction

    assign unused_addr_lsb = ^bus.branch_addr_i[1:0];

    // Reservation: outstanding plus buffered words never exceed the FIFO size
    assign ot_room   = ot_q < OTW'(MAX_OT);
    assign can_issue = bus.req_i && boot_q && (state_q != ERR_HALT) && ot_room
                       && ((SW'(ot_q) + SW'(fifo_cnt_q)) < SW'(DEPTH));

    // Bus request: a branch redirects in the same cycle, otherwise the FSM state decides
    always_comb begin
        req      = 1'b0;
        req_addr = addr_q;
        if (bus.branch_i) begin
            req      = bus.req_i && ot_room;
            req_addr = {bus.branch_addr_i[31:2], 2'b00};
        end else begin
            case (state_q)
                IDLE:     req = can_issue;
                WAIT_GNT: req = 1'b1;
                default:  req = 1'b0;
            endcase
        end
    end

    assign gnt       = req && bus.instr_gnt_i;
    assign rvalid    = bus.instr_rvalid_i;
    // Responses of a squashed stream (and the one arriving with the branch) are dropped
    assign drop      = bus.branch_i || (discard_q != '0);
    assign rsp_acc   = rvalid && !drop;
    assign rsp_err   = rsp_acc && bus.instr_err_i;
    assign rsp_addr  = aq_mem[aq_rd_q];
    assign ot_nxt    = ot_q + OTW'(gnt) - OTW'(rvalid);
    assign head_vld  = fifo_cnt_q != '0;
`ifdef RISCV_PREFETCH_BYPASS_EN
    assign byp       = rsp_acc && !head_vld;
`else
    assign byp       = 1'b0;
`endif
    assign fetch_vld = !bus.branch_i && (head_vld || byp);
    assign fetch_pop = fetch_vld && bus.fetch_ready_i;
    assign fifo_pop  = fetch_pop && head_vld;
    assign fifo_push = rsp_acc && !(byp && bus.fetch_ready_i);

    // Output word: FIFO head, or the response arriving this cycle when bypassing an empty FIFO
    always_comb begin
        out_rdata = '0;
        out_addr  = '0;
        out_err   = 1'b0;
        if (head_vld) begin
            out_rdata = rdata_mem[rd_ptr_q];
            out_addr  = addr_mem[rd_ptr_q];
            out_err   = err_mem[rd_ptr_q];
        end
`ifdef RISCV_PREFETCH_BYPASS_EN
        else if (byp) begin
            out_rdata = bus.instr_rdata_i;
            out_addr  = rsp_addr;
            out_err   = bus.instr_err_i;
        end
`endif
    end

    assign bus.instr_req_o   = req;
    assign bus.instr_addr_o  = req_addr;
    assign bus.fetch_valid_o = fetch_vld;
    assign bus.fetch_rdata_o = out_rdata;
    assign bus.fetch_addr_o  = out_addr;
    assign bus.fetch_err_o   = out_err;
    assign bus.busy_o        = req || (ot_q != '0);

    // Control FSM and next sequential fetch address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            boot_q  <= 1'b0;
        end else begin
            if (gnt) begin
                addr_q <= req_addr + 32'd4;
            end else if (bus.branch_i) begin
                addr_q <= req_addr;
            end
            if (bus.branch_i) begin
                boot_q  <= 1'b1;
                state_q <= (req && !gnt) ? WAIT_GNT : IDLE;
            end else if (rsp_err) begin
                state_q <= ERR_HALT;
            end else begin
                case (state_q)
                    IDLE:     if (req && !gnt) state_q <= WAIT_GNT;
                    WAIT_GNT: if (gnt) state_q <= IDLE;
                    default:  state_q <= ERR_HALT;
                endcase
            end
        end
    end

    // Outstanding / discard counters and the outstanding-address queue pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ot_q      <= '0;
            discard_q <= '0;
            aq_wr_q   <= '0;
            aq_rd_q   <= '0;
        end else begin
            ot_q <= ot_nxt;
            if (bus.branch_i) begin
                discard_q <= ot_q - OTW'(rvalid);
            end else if (rvalid && (discard_q != '0)) begin
                discard_q <= discard_q - OTW'(1);
            end else if (rsp_err) begin
                discard_q <= ot_nxt;
            end
            if (gnt) aq_wr_q <= aq_inc(aq_wr_q);
            if (rvalid) aq_rd_q <= aq_inc(aq_rd_q);
        end
    end

    // Response FIFO pointers and occupancy; a branch empties it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else if (bus.branch_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (fifo_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (fifo_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            fifo_cnt_q <= fifo_cnt_q + CW'(fifo_push) - CW'(fifo_pop);
        end
    end

    // Storage: granted addresses and buffered responses
    always_ff @(posedge clk) begin
        if (gnt) aq_mem[aq_wr_q] <= req_addr;
        if (fifo_push) begin
            rdata_mem[wr_ptr_q] <= bus.instr_rdata_i;
            addr_mem[wr_ptr_q]  <= rsp_addr;
            err_mem[wr_ptr_q]   <= bus.instr_err_i;
        end
    end
endmodule
